pipeline_stall_controller: RTL and testbench
============================================

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, max cycles in MEM_WAIT before abort.
REQ-002 The block SHALL have parameter CNT_W, default 8, width of the stall-cycle counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 loadUseHazard  input  1  load-use hazard detected in ID.
REQ-006 branchTaken  input  1  branch resolved taken in ID.
REQ-007 memReq  input  1  EX/MEM holds memRead or memWrite.
REQ-008 memReady  input  1  data memory completion, valid only in MEM_WAIT.
REQ-009 pcWrite, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write  output  1 each  stage register write enables.
REQ-010 IF_ID_flush  output  1  clear IF/ID to NOP.
REQ-011 controlSel  output  1  1 = pass ID control to ID/EX; 0 = insert bubble.
REQ-012 memStart  output  1  one-cycle data memory access start pulse.
REQ-013 memError  output  1  sticky timeout flag.
REQ-014 stallCount  output  CNT_W  saturating count of frozen or stalled cycles.

Function
REQ-015 The FSM SHALL have states RUN, MEM_WAIT, MEM_DONE.
REQ-016 In RUN with memReq=1, the block SHALL assert memStart and drive all write enables 0 and controlSel 1 that cycle, then enter MEM_WAIT.
REQ-017 In MEM_WAIT, the block SHALL hold all write enables 0, memStart 0 and IF_ID_flush 0, and ignore loadUseHazard and branchTaken.
REQ-018 In MEM_WAIT with memReady=1, the block SHALL enter MEM_DONE next cycle.
REQ-019 A 0-to-TIMEOUT wait counter SHALL clear on MEM_WAIT entry and increment each MEM_WAIT cycle without memReady.
REQ-020 When the wait counter reaches TIMEOUT without memReady, the block SHALL set memError and enter MEM_DONE.
REQ-021 In MEM_DONE, the block SHALL drive all write enables 1 and controlSel 1, ignore memReq, and return to RUN.
REQ-022 MEM_DONE SHALL NOT ignore load-use; if loadUseHazard=1 there, pcWrite, IF_ID_write and controlSel SHALL be 0.
REQ-023 In RUN with memReq=0 and loadUseHazard=1, pcWrite, IF_ID_write and controlSel SHALL be 0; other enables SHALL be 1.
REQ-024 In RUN with memReq=0, loadUseHazard=0 and branchTaken=1, IF_ID_flush SHALL be 1 and all enables 1.
REQ-025 Priority SHALL be memory freeze > load-use stall > branch flush; a suppressed branch flush is re-evaluated next cycle.
REQ-026 With no condition active in RUN, all enables and controlSel SHALL be 1, and IF_ID_flush and memStart SHALL be 0.
REQ-027 stallCount SHALL increment on every cycle with pcWrite=0 and saturate at 2^CNT_W-1.
REQ-028 memError SHALL remain 1 until reset.
REQ-029 All outputs except stallCount, memError and state SHALL be combinational from state and inputs, with zero-cycle latency.

Reset
REQ-030 On rst=0 at a clock edge, state SHALL become RUN, and the wait counter, stallCount and memError SHALL become 0.
REQ-031 Reset SHALL take effect from any state, including mid-MEM_WAIT, and SHALL NOT issue memStart.
REQ-032 While rst=0, outputs SHALL follow the RUN decode with memStart forced to 0.

Structure
REQ-033 The state encoding (RUN=0, MEM_WAIT=1, MEM_DONE=2, 2 bits) SHALL be shared constants in the pipeline package.
REQ-034 The saturating counter SHALL be sub-module sat_counter, parameterised by width.

Verification
REQ-035 Load-use: loadUseHazard=1 for 1 cycle in RUN -> pcWrite=IF_ID_write=controlSel=0 that cycle, stallCount=1.
REQ-036 Memory: memReq=1, memReady after 3 MEM_WAIT cycles -> memStart one pulse, 4 frozen cycles, MEM_DONE enables=1, stallCount=4.
REQ-037 Timeout: memReq=1, memReady held 0 -> after 15 MEM_WAIT cycles memError=1, MEM_DONE, then RUN.
REQ-038 Priority: loadUseHazard=branchTaken=1 in RUN -> stall, IF_ID_flush=0; next cycle with loadUseHazard=0 -> flush=1.
REQ-039 Reset mid-wait: rst=0 during MEM_WAIT -> next cycle in RUN, stallCount=0, memError=0, no memStart.
REQ-040 Saturation: CNT_W=2, 5 consecutive stall cycles -> stallCount=3.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared constants for the pipeline stall controller: FSM state encoding and
// the bundle of stage-control outputs.
package pipeline_stall_controller_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MEM_DONE = 2'd2;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_write;
    logic if_id_flush;
    logic control_sel;
    logic mem_start;
  } ctrl_t;

  // Free-running pipeline: every stage advances, ID control passes through.
  function automatic ctrl_t ctrl_run_default();
    ctrl_t c;
    c = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
          ex_mem_write: 1'b1, mem_wb_write: 1'b1, if_id_flush: 1'b0,
          control_sel: 1'b1, mem_start: 1'b0};
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard controller: memory freeze with timeout, load-use stall and
// branch flush, plus a saturating count of cycles in which the PC was held.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loadUseHazard,
  input  logic             branchTaken,
  input  logic             memReq,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             controlSel,
  output logic             memStart,
  output logic             memError,
  output logic [CNT_W-1:0] stallCount,
  output logic [1:0]       state
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [1:0]        state_q, state_d, dec_state;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              mem_error_q, mem_error_d;
  ctrl_t             ctrl;

  // During reset the outputs decode as RUN regardless of the held state.
  assign dec_state = rst ? state_q : RUN;
  assign wait_inc  = wait_q + WAIT_W'(1);

  always_comb begin
    ctrl = ctrl_run_default();
    case (dec_state)
      RUN: begin
        if (memReq) begin
          ctrl.pc_write     = 1'b0;
          ctrl.if_id_write  = 1'b0;
          ctrl.id_ex_write  = 1'b0;
          ctrl.ex_mem_write = 1'b0;
          ctrl.mem_wb_write = 1'b0;
          ctrl.mem_start    = rst;
        end else if (loadUseHazard) begin
          ctrl.pc_write    = 1'b0;
          ctrl.if_id_write = 1'b0;
          ctrl.control_sel = 1'b0;
        end else if (branchTaken) begin
          ctrl.if_id_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        ctrl.pc_write     = 1'b0;
        ctrl.if_id_write  = 1'b0;
        ctrl.id_ex_write  = 1'b0;
        ctrl.ex_mem_write = 1'b0;
        ctrl.mem_wb_write = 1'b0;
      end
      MEM_DONE: begin
        // memReq is still high for the completing access; it must not re-freeze.
        if (loadUseHazard) begin
          ctrl.pc_write    = 1'b0;
          ctrl.if_id_write = 1'b0;
          ctrl.control_sel = 1'b0;
        end else if (branchTaken) begin
          ctrl.if_id_flush = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_error_d = mem_error_q;
    case (state_q)
      RUN: begin
        if (memReq) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (memReady) begin
          state_d = MEM_DONE;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_W'(TIMEOUT)) begin
            mem_error_d = 1'b1;
            state_d     = MEM_DONE;
          end
        end
      end
      MEM_DONE: state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_error_q <= mem_error_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (~ctrl.pc_write),
    .count_o (stallCount)
  );

  assign pcWrite      = ctrl.pc_write;
  assign IF_ID_write  = ctrl.if_id_write;
  assign ID_EX_write  = ctrl.id_ex_write;
  assign EX_MEM_write = ctrl.ex_mem_write;
  assign MEM_WB_write = ctrl.mem_wb_write;
  assign IF_ID_flush  = ctrl.if_id_flush;
  assign controlSel   = ctrl.control_sel;
  assign memStart     = ctrl.mem_start;
  assign memError     = mem_error_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: a default instance plus a
// 2-bit-counter instance sharing the same stimulus for saturation.
module tb_pipeline_stall_controller;

  // Output vector order: pcWrite, IF_ID_write, ID_EX_write, EX_MEM_write,
  // MEM_WB_write, IF_ID_flush, controlSel, memStart.
  localparam logic [7:0] O_IDLE   = 8'b1111_1010;
  localparam logic [7:0] O_MEMREQ = 8'b0000_0011;
  localparam logic [7:0] O_FROZEN = 8'b0000_0010;
  localparam logic [7:0] O_LU     = 8'b0011_1000;
  localparam logic [7:0] O_BR     = 8'b1111_1110;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic loadUseHazard = 1'b0, branchTaken = 1'b0, memReq = 1'b0, memReady = 1'b0;

  logic       pcWrite, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
  logic       IF_ID_flush, controlSel, memStart, memError;
  logic [7:0] stallCount;
  logic [1:0] state;

  logic       pcWrite2, IF_ID_write2, ID_EX_write2, EX_MEM_write2, MEM_WB_write2;
  logic       IF_ID_flush2, controlSel2, memStart2, memError2;
  logic [1:0] stallCount2;
  logic [1:0] state2;

  int checks = 0;
  int failures = 0;
  int cnt_e = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller dut (
    .clk(clk), .rst(rst), .loadUseHazard(loadUseHazard), .branchTaken(branchTaken),
    .memReq(memReq), .memReady(memReady), .pcWrite(pcWrite), .IF_ID_write(IF_ID_write),
    .ID_EX_write(ID_EX_write), .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
    .IF_ID_flush(IF_ID_flush), .controlSel(controlSel), .memStart(memStart),
    .memError(memError), .stallCount(stallCount), .state(state)
  );

  pipeline_stall_controller #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .loadUseHazard(loadUseHazard), .branchTaken(branchTaken),
    .memReq(memReq), .memReady(memReady), .pcWrite(pcWrite2), .IF_ID_write(IF_ID_write2),
    .ID_EX_write(ID_EX_write2), .EX_MEM_write(EX_MEM_write2), .MEM_WB_write(MEM_WB_write2),
    .IF_ID_flush(IF_ID_flush2), .controlSel(controlSel2), .memStart(memStart2),
    .memError(memError2), .stallCount(stallCount2), .state(state2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, then check the combinational
  // decode and the registered state reached by the preceding rising edges.
  task automatic cyc(input string tag, input logic r, input logic lu, input logic br,
                     input logic mr, input logic rdy, input logic [7:0] exp_out,
                     input logic [1:0] exp_st, input int exp_cnt, input logic exp_err);
    int exp_cnt2;
    @(negedge clk);
    rst = r; loadUseHazard = lu; branchTaken = br; memReq = mr; memReady = rdy;
    #1;
    exp_cnt2 = (exp_cnt > 3) ? 3 : exp_cnt;
    check({tag, "/out"}, {24'd0, pcWrite, IF_ID_write, ID_EX_write, EX_MEM_write,
                          MEM_WB_write, IF_ID_flush, controlSel, memStart}, {24'd0, exp_out});
    check({tag, "/state"}, {30'd0, state}, {30'd0, exp_st});
    check({tag, "/stallCount"}, {24'd0, stallCount}, exp_cnt);
    check({tag, "/stallCount_w2"}, {30'd0, stallCount2}, exp_cnt2);
    check({tag, "/memError"}, {31'd0, memError}, {31'd0, exp_err});
  endtask

  initial begin
    // Reset: RUN decode with memStart suppressed.
    cyc("rst_memreq", 0, 0, 0, 1, 0, O_FROZEN, 2'd0, 0, 0);
    cyc("rst_idle",   0, 0, 0, 0, 0, O_IDLE,   2'd0, 0, 0);
    cyc("idle",       1, 0, 0, 0, 0, O_IDLE,   2'd0, 0, 0);
    // Load-use then priority load-use over branch, branch re-evaluated.
    cyc("loaduse",    1, 1, 0, 0, 0, O_LU,     2'd0, 0, 0);
    cyc("after_lu",   1, 0, 0, 0, 0, O_IDLE,   2'd0, 1, 0);
    cyc("lu_and_br",  1, 1, 1, 0, 0, O_LU,     2'd0, 1, 0);
    cyc("br_retry",   1, 0, 1, 0, 0, O_BR,     2'd0, 2, 0);
    cyc("idle2",      1, 0, 0, 0, 0, O_IDLE,   2'd0, 2, 0);
    // Memory access completing in the third MEM_WAIT cycle.
    cyc("mem_start",  1, 0, 0, 1, 0, O_MEMREQ, 2'd0, 2, 0);
    cyc("wait1",      1, 1, 1, 1, 0, O_FROZEN, 2'd1, 3, 0);
    cyc("wait2",      1, 0, 0, 1, 0, O_FROZEN, 2'd1, 4, 0);
    cyc("wait3_rdy",  1, 0, 0, 1, 1, O_FROZEN, 2'd1, 5, 0);
    cyc("mem_done",   1, 0, 0, 1, 0, O_IDLE,   2'd2, 6, 0);
    cyc("back_run",   1, 0, 0, 0, 0, O_IDLE,   2'd0, 6, 0);
    // Timeout: 15 MEM_WAIT cycles without memReady.
    cyc("to_start",   1, 0, 0, 1, 0, O_MEMREQ, 2'd0, 6, 0);
    cnt_e = 7;
    for (int i = 0; i < 15; i++) begin
      cyc($sformatf("to_wait%0d", i), 1, 0, 0, 1, 0, O_FROZEN, 2'd1, cnt_e, 0);
      cnt_e++;
    end
    cyc("to_done_lu", 1, 1, 0, 1, 0, O_LU,     2'd2, 22, 1);
    cyc("to_run",     1, 0, 0, 0, 0, O_IDLE,   2'd0, 23, 1);
    cyc("err_sticky", 1, 0, 0, 0, 0, O_IDLE,   2'd0, 23, 1);
    // Reset in the middle of MEM_WAIT.
    cyc("mw_start",   1, 0, 0, 1, 0, O_MEMREQ, 2'd0, 23, 1);
    cyc("mw_wait",    1, 0, 0, 1, 0, O_FROZEN, 2'd1, 24, 1);
    cyc("mw_reset",   0, 0, 0, 1, 0, O_FROZEN, 2'd1, 25, 1);
    cyc("post_reset", 1, 0, 0, 0, 0, O_IDLE,   2'd0, 0, 0);
    // Five consecutive stalls: 2-bit counter saturates at 3.
    cnt_e = 0;
    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("sat_lu%0d", i), 1, 1, 0, 0, 0, O_LU, 2'd0, cnt_e, 0);
      cnt_e++;
    end
    cyc("sat_end",    1, 0, 0, 0, 0, O_IDLE,   2'd0, 5, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
